// File: rtl/matrix_entry_streamer.sv
// ============================================================================
// Module   : matrix_entry_streamer
// Brief    : Snapshots a packed DIM_MAX x DIM_MAX matrix on Start and streams
//            the active top-left NxN entries row-major over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_entry_streamer #(
    parameter int DIM_MAX = 8,
    parameter int ENTRY_W = 4
) (
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic                                 Start,
    input  logic                                 Abort,
    input  logic [3:0]                           Size,
    input  logic [DIM_MAX*DIM_MAX*ENTRY_W-1:0]   input_arr_flat,
    input  logic                                 Out_Ready,
    output logic                                 Out_Valid,
    output logic [ENTRY_W-1:0]                   Out_Entry,
    output logic [$clog2(DIM_MAX)-1:0]           Out_Row,
    output logic [$clog2(DIM_MAX)-1:0]           Out_Col,
    output logic                                 Out_Last,
    output logic                                 Busy,
    output logic                                 Done
);

    localparam int c_IDX_W = $clog2(DIM_MAX);
    localparam int c_ARR_W = DIM_MAX * DIM_MAX * ENTRY_W;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]           r_state;
    logic [c_ARR_W-1:0]   r_shadow;
    logic [c_IDX_W-1:0]   r_last_idx;
    logic [c_IDX_W-1:0]   r_row;
    logic [c_IDX_W-1:0]   r_col;
    logic                 r_valid;
    logic [ENTRY_W-1:0]   r_entry;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;

    logic [c_IDX_W-1:0]   w_last_idx_new;
    logic [c_IDX_W-1:0]   w_row_nxt;
    logic [c_IDX_W-1:0]   w_col_nxt;
    logic                 w_final;
    logic                 w_last_nxt;
    int                   w_bit_idx;
    logic [ENTRY_W-1:0]   w_entry_nxt;

    // Out-of-range sizes fall back to the full matrix; stored as N-1.
    always_comb begin
        if ((Size == 4'd0) || (int'(Size) > DIM_MAX)) begin
            w_last_idx_new = c_IDX_W'(DIM_MAX - 1);
        end else begin
            w_last_idx_new = c_IDX_W'(Size - 4'd1);
        end
    end

    always_comb begin
        w_final = (r_row == r_last_idx) && (r_col == r_last_idx);
        if (r_col == r_last_idx) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + c_IDX_W'(1);
        end else begin
            w_col_nxt = r_col + c_IDX_W'(1);
            w_row_nxt = r_row;
        end
        w_last_nxt  = (w_row_nxt == r_last_idx) && (w_col_nxt == r_last_idx);
        w_bit_idx   = (int'(w_row_nxt) * DIM_MAX + int'(w_col_nxt)) * ENTRY_W;
        w_entry_nxt = r_shadow[w_bit_idx +: ENTRY_W];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= c_IDLE;
            r_shadow   <= '0;
            r_last_idx <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_valid    <= 1'b0;
            r_entry    <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (Start && !Abort) begin
                        r_shadow   <= input_arr_flat;
                        r_last_idx <= w_last_idx_new;
                        r_busy     <= 1'b1;
                        r_state    <= c_LOAD;
                    end
                end

                c_LOAD: begin
                    r_row <= '0;
                    r_col <= '0;
                    if (Abort) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                        r_entry <= r_shadow[ENTRY_W-1:0];
                        r_last  <= (r_last_idx == '0);
                        r_state <= c_STREAM;
                    end
                end

                c_STREAM: begin
                    if (Abort) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= c_IDLE;
                    end else if (Out_Ready) begin
                        if (w_final) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= c_DONE;
                        end else begin
                            r_row   <= w_row_nxt;
                            r_col   <= w_col_nxt;
                            r_entry <= w_entry_nxt;
                            r_last  <= w_last_nxt;
                        end
                    end
                end

                default: begin
                    // DONE lasts one cycle whether or not Abort is present.
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Out_Valid = r_valid;
    assign Out_Entry = r_entry;
    assign Out_Row   = r_row;
    assign Out_Col   = r_col;
    assign Out_Last  = r_last;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_matrix_entry_streamer.sv
// ============================================================================
// Module   : tb_matrix_entry_streamer
// Brief    : Self-checking bench for matrix_entry_streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_entry_streamer;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic         Abort;
    logic [3:0]   Size;
    logic [255:0] input_arr_flat;
    logic         Out_Ready;
    logic         Out_Valid;
    logic [3:0]   Out_Entry;
    logic [2:0]   Out_Row;
    logic [2:0]   Out_Col;
    logic         Out_Last;
    logic         Busy;
    logic         Done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] entry;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0] size;
        int         mode;
        int         exp_n;
    } vec_t;

    beat_t exp_q[$];

    matrix_entry_streamer #(.DIM_MAX(8), .ENTRY_W(4)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .Abort          (Abort),
        .Size           (Size),
        .input_arr_flat (input_arr_flat),
        .Out_Ready      (Out_Ready),
        .Out_Valid      (Out_Valid),
        .Out_Entry      (Out_Entry),
        .Out_Row        (Out_Row),
        .Out_Col        (Out_Col),
        .Out_Last       (Out_Last),
        .Busy           (Busy),
        .Done           (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: row-major list of the top-left NxN entries of the snapshot.
    task automatic build_model(input logic [255:0] mat, input logic [3:0] sz);
        int n;
        n = (sz == 0 || sz > 8) ? 8 : int'(sz);
        exp_q.delete();
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                exp_q.push_back('{mat[32*r + 4*c +: 4], 3'(r), 3'(c), (r == n-1) && (c == n-1)});
    endtask

    function automatic logic ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic run_stream(input logic [255:0] mat, input logic [3:0] sz, input int mode,
                              input bit edit, output int n_xfer);
        int cyc;
        int budget;
        build_model(mat, sz);
        budget = exp_q.size() * 8 + 20;
        n_xfer = 0;
        cyc    = 0;
        @(negedge Clk);
        input_arr_flat = mat;
        Size      = sz;
        Start     = 1'b1;
        Out_Ready = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("load_busy_valid", {Busy, Out_Valid}, 2'b10);
        @(negedge Clk);
        while (exp_q.size() > 0 && cyc < budget) begin
            check("stream_valid", Out_Valid, 1'b1);
            check("beat", exp_q[0], {Out_Entry, Out_Row, Out_Col, Out_Last});
            Out_Ready = ready_pat(mode, cyc);
            if (Out_Ready) begin
                void'(exp_q.pop_front());
                n_xfer++;
                if (edit) input_arr_flat = '1;
            end
            cyc++;
            @(negedge Clk);
        end
        check("stream_timeout", exp_q.size(), 0);
        check("done_pulse", {Done, Out_Valid, Busy, Out_Last}, 4'b1000);
        Out_Ready = 1'b1;
        @(negedge Clk);
        check("done_clear", {Done, Out_Valid, Busy}, 3'b000);
    endtask

    initial begin
        logic [255:0] mat;
        vec_t         tbl[7];
        int           nx;

        Reset_n = 1'b0;
        Start = 1'b0; Abort = 1'b0; Size = 4'd0;
        input_arr_flat = '0; Out_Ready = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", {Out_Valid, Out_Entry, Out_Row, Out_Col, Out_Last, Busy, Done}, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_after_reset", {Out_Valid, Busy, Done}, 3'b000);

        // Identity pattern, full 8x8 with continuous ready
        mat = '0;
        for (int i = 0; i < 8; i++) mat[32*i + 4*i +: 4] = 4'd1;
        run_stream(mat, 4'd8, 0, 1'b0, nx);
        check("identity_count", nx, 64);

        // 3x3 ordering with entry value 3r+c+1
        mat = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) mat[32*r + 4*c +: 4] = 4'(3*r + c + 1);
        run_stream(mat, 4'd3, 0, 1'b0, nx);
        check("order3_count", nx, 9);

        // 2x2 under backpressure while the live array is overwritten
        run_stream(mat, 4'd2, 1, 1'b1, nx);
        check("bp_count", nx, 4);

        // Size table with random matrices and random ready
        tbl[0] = '{4'd0,  2, 64};
        tbl[1] = '{4'd1,  0, 1};
        tbl[2] = '{4'd1,  2, 1};
        tbl[3] = '{4'd5,  2, 25};
        tbl[4] = '{4'd9,  0, 64};
        tbl[5] = '{4'd15, 2, 64};
        tbl[6] = '{4'd7,  2, 49};
        for (int t = 0; t < 7; t++) begin
            for (int w = 0; w < 8; w++) mat[32*w +: 32] = $urandom;
            run_stream(mat, tbl[t].size, tbl[t].mode, 1'b0, nx);
            check("table_count", nx, tbl[t].exp_n);
        end

        // Abort at transfer 5 of a 4x4 stream, with an ignored Start at transfer 2
        for (int w = 0; w < 8; w++) mat[32*w +: 32] = $urandom;
        build_model(mat, 4'd4);
        @(negedge Clk);
        input_arr_flat = mat; Size = 4'd4; Start = 1'b1; Out_Ready = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        for (int k = 0; k < 6; k++) begin
            check("abort_valid", Out_Valid, 1'b1);
            check("abort_beat", exp_q[k], {Out_Entry, Out_Row, Out_Col, Out_Last});
            Start = (k == 2);
            Abort = (k == 5);
            @(negedge Clk);
        end
        Abort = 1'b0;
        check("abort_outputs", {Out_Valid, Busy, Done, Out_Last}, 4'b0000);
        @(negedge Clk);
        check("abort_no_done", {Out_Valid, Busy, Done}, 3'b000);
        run_stream(mat, 4'd4, 0, 1'b0, nx);
        check("restart_count", nx, 16);

        // Start and Abort together in IDLE
        @(negedge Clk);
        Start = 1'b1; Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        check("start_abort_busy", Busy, 1'b0);
        @(negedge Clk);
        check("start_abort_valid", {Out_Valid, Busy}, 2'b00);

        // Abort during LOAD
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b1;
        check("load_abort_busy", Busy, 1'b1);
        @(negedge Clk);
        Abort = 1'b0;
        check("load_abort_idle", {Busy, Out_Valid}, 2'b00);
        @(negedge Clk);
        check("load_abort_stay", {Busy, Out_Valid, Done}, 3'b000);

        // Asynchronous reset between clock edges mid-stream
        Size = 4'd8; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        check("pre_reset_valid", Out_Valid, 1'b1);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 check("async_reset", {Out_Valid, Busy, Done, Out_Row, Out_Col}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check("post_reset_idle", {Out_Valid, Busy, Done}, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
